// File: rtl/ysyx_22040088_idu_pkg.sv
// Shared decode definitions for the IDU pipeline stage: opcode constants,
// instruction format codes, per-opcode register usage and immediate assembly.
package ysyx_22040088_idu_pkg;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OP32   = 7'b0111011;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd7
    } fmt_e;

    typedef struct packed {
        fmt_e fmt;
        logic use_rs1;
        logic use_rs2;
        logic use_rd;
    } dec_t;

    // Format and register usage implied by the opcode alone.
    function automatic dec_t decode_op(input logic [6:0] opcode);
        dec_t d;
        d.fmt     = FMT_ILL;
        d.use_rs1 = 1'b0;
        d.use_rs2 = 1'b0;
        d.use_rd  = 1'b0;
        case (opcode)
            OP_IMM, OP_LOAD, OP_JALR, OP_IMM32: begin
                d.fmt = FMT_I; d.use_rs1 = 1'b1; d.use_rd = 1'b1;
            end
            OP_STORE: begin
                d.fmt = FMT_S; d.use_rs1 = 1'b1; d.use_rs2 = 1'b1;
            end
            OP_BRANCH: begin
                d.fmt = FMT_B; d.use_rs1 = 1'b1; d.use_rs2 = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                d.fmt = FMT_U; d.use_rd = 1'b1;
            end
            OP_JAL: begin
                d.fmt = FMT_J; d.use_rd = 1'b1;
            end
            OP_OP, OP_OP32: begin
                d.fmt = FMT_R; d.use_rs1 = 1'b1; d.use_rs2 = 1'b1; d.use_rd = 1'b1;
            end
            default: d.fmt = FMT_ILL;
        endcase
        return d;
    endfunction

    // 32-bit sign-extended immediate; R and ILL carry no immediate.
    function automatic logic [31:0] imm_of(input fmt_e fmt, input logic [31:0] inst);
        logic [31:0] imm;
        case (fmt)
            FMT_I:   imm = {{20{inst[31]}}, inst[31:20]};
            FMT_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_U:   imm = {inst[31:12], 12'b0};
            FMT_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = 32'd0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/ysyx_22040088_idu_pipe_if.sv
// IFU -> IDU -> EXU handshake, writeback and flush bundle for the decode stage.
// slave: the decode stage itself; master: the surrounding pipeline.
interface ysyx_22040088_idu_pipe_if #(parameter int XLEN = 64);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [31:0]     out_inst;
    logic [XLEN-1:0] out_rs1_data;
    logic [XLEN-1:0] out_rs2_data;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_fmt;
    logic [4:0]      out_rd;
    logic            out_rf_we;
    logic            out_illegal;
    logic            wb_valid;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            flush;

    modport slave (
        input  in_valid, in_inst, in_pc, out_ready, wb_valid, wb_rd, wb_data, flush,
        output in_ready, out_valid, out_pc, out_inst, out_rs1_data, out_rs2_data,
               out_imm, out_fmt, out_rd, out_rf_we, out_illegal
    );

    modport master (
        output in_valid, in_inst, in_pc, out_ready, wb_valid, wb_rd, wb_data, flush,
        input  in_ready, out_valid, out_pc, out_inst, out_rs1_data, out_rs2_data,
               out_imm, out_fmt, out_rd, out_rf_we, out_illegal
    );
endinterface

// File: rtl/ysyx_22040088_regfile_nr.sv
// Integer register file: NREG x XLEN, two combinational read ports, one
// synchronous write port. Entry 0 is a constant zero, so writes to x0 vanish.
module ysyx_22040088_regfile_nr #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr1,
    output logic [XLEN-1:0] rdata1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata2
);

    logic [NREG-1:0][XLEN-1:0] rows;

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_row
            if (gi == 0) begin : g_zero
                assign rows[gi] = '0;
            end else begin : g_reg
                logic [XLEN-1:0] row_reg;
                // One architectural register, cleared by reset, loaded on a matching write.
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        row_reg <= '0;
                    end else if (we && (waddr == AW'(gi))) begin
                        row_reg <= wdata;
                    end
                end
                assign rows[gi] = row_reg;
            end
        end
    endgenerate

    assign rdata1 = rows[raddr1];
    assign rdata2 = rows[raddr2];

endmodule

// File: rtl/ysyx_22040088_idu_pipe.sv
// Pipelined RV decode stage with a one-entry output register and a busy
// scoreboard that stalls RAW/WAW hazards until the matching writeback.
// Optional feature macro: YSYX_22040088_IDU_BYPASS_EN forwards a same-cycle
// writeback to a waiting source operand instead of stalling an extra cycle.
module ysyx_22040088_idu_pipe
    import ysyx_22040088_idu_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int NREG = 32
) (
    input logic clk,
    input logic rst,
    ysyx_22040088_idu_pipe_if.slave bus
);

    localparam int AW = $clog2(NREG);

    logic [4:0]      rs1_idx, rs2_idx, rd_idx;
    dec_t            dec;
    logic            bad_idx, illegal;
    fmt_e            fmt;
    logic            use1, use2, rf_we;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm_ext;
    logic [XLEN-1:0] rf_rdata1, rf_rdata2, rs1_val, rs2_val;
    logic            wb_we, fwd1, fwd2;
    logic            busy1, busy2, busy_rd, hazard, in_ready, fire;
    logic [NREG-1:0] busy_reg, busy_next;

    logic            out_valid_reg;
    logic [XLEN-1:0] out_pc_reg, out_rs1_reg, out_rs2_reg, out_imm_reg;
    logic [31:0]     out_inst_reg;
    logic [2:0]      out_fmt_reg;
    logic [4:0]      out_rd_reg;
    logic            out_we_reg, out_ill_reg;

    function automatic logic idx_ok(input logic [4:0] idx);
        return int'(idx) < NREG;
    endfunction

    assign rs1_idx = bus.in_inst[19:15];
    assign rs2_idx = bus.in_inst[24:20];
    assign rd_idx  = bus.in_inst[11:7];

    // Decode: an index beyond the register file turns the whole instruction illegal.
    always_comb begin
        dec     = decode_op(bus.in_inst[6:0]);
        bad_idx = (dec.use_rs1 & !idx_ok(rs1_idx)) |
                  (dec.use_rs2 & !idx_ok(rs2_idx)) |
                  (dec.use_rd  & !idx_ok(rd_idx));
        illegal = (dec.fmt == FMT_ILL) | bad_idx;
        fmt     = illegal ? FMT_ILL : dec.fmt;
        use1    = dec.use_rs1 & !illegal;
        use2    = dec.use_rs2 & !illegal;
        rf_we   = dec.use_rd & !illegal & (rd_idx != 5'd0);
        imm32   = imm_of(fmt, bus.in_inst);
    end

    generate
        if (XLEN == 32) begin : g_imm_native
            assign imm_ext = imm32;
        end else begin : g_imm_sext
            assign imm_ext = {{(XLEN-32){imm32[31]}}, imm32};
        end
    endgenerate

    ysyx_22040088_regfile_nr #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (wb_we),
        .waddr  (bus.wb_rd[AW-1:0]),
        .wdata  (bus.wb_data),
        .raddr1 (rs1_idx[AW-1:0]),
        .rdata1 (rf_rdata1),
        .raddr2 (rs2_idx[AW-1:0]),
        .rdata2 (rf_rdata2)
    );

    // Hazard detection, optional forwarding and operand selection.
    always_comb begin
        wb_we = bus.wb_valid & idx_ok(bus.wb_rd);
`ifdef YSYX_22040088_IDU_BYPASS_EN
        fwd1  = wb_we & use1 & (bus.wb_rd == rs1_idx) & (rs1_idx != 5'd0);
        fwd2  = wb_we & use2 & (bus.wb_rd == rs2_idx) & (rs2_idx != 5'd0);
`else
        fwd1  = 1'b0;
        fwd2  = 1'b0;
`endif
        busy1    = use1  & busy_reg[rs1_idx[AW-1:0]] & !fwd1;
        busy2    = use2  & busy_reg[rs2_idx[AW-1:0]] & !fwd2;
        busy_rd  = rf_we & busy_reg[rd_idx[AW-1:0]];
        hazard   = busy1 | busy2 | busy_rd;
        in_ready = (!out_valid_reg | bus.out_ready) & !hazard & !bus.flush;
        fire     = bus.in_valid & in_ready;
        rs1_val  = !use1 ? '0 : (fwd1 ? bus.wb_data : rf_rdata1);
        rs2_val  = !use2 ? '0 : (fwd2 ? bus.wb_data : rf_rdata2);
    end

    // Scoreboard update: flush wipes everything; a new claim beats a same-index writeback.
    always_comb begin
        busy_next = busy_reg;
        if (bus.flush) begin
            busy_next = '0;
        end else begin
            if (wb_we) busy_next[bus.wb_rd[AW-1:0]] = 1'b0;
            if (fire && rf_we) busy_next[rd_idx[AW-1:0]] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Output entry register and scoreboard state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_reg <= 1'b0;
            out_pc_reg    <= '0;
            out_inst_reg  <= '0;
            out_rs1_reg   <= '0;
            out_rs2_reg   <= '0;
            out_imm_reg   <= '0;
            out_fmt_reg   <= '0;
            out_rd_reg    <= '0;
            out_we_reg    <= 1'b0;
            out_ill_reg   <= 1'b0;
            busy_reg      <= '0;
        end else begin
            if (bus.flush) begin
                out_valid_reg <= 1'b0;
            end else if (fire) begin
                out_valid_reg <= 1'b1;
            end else if (bus.out_ready) begin
                out_valid_reg <= 1'b0;
            end
            if (fire) begin
                out_pc_reg   <= bus.in_pc;
                out_inst_reg <= bus.in_inst;
                out_rs1_reg  <= rs1_val;
                out_rs2_reg  <= rs2_val;
                out_imm_reg  <= imm_ext;
                out_fmt_reg  <= fmt;
                out_rd_reg   <= rd_idx;
                out_we_reg   <= rf_we;
                out_ill_reg  <= illegal;
            end
            busy_reg <= busy_next;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = out_valid_reg;
    assign bus.out_pc       = out_pc_reg;
    assign bus.out_inst     = out_inst_reg;
    assign bus.out_rs1_data = out_rs1_reg;
    assign bus.out_rs2_data = out_rs2_reg;
    assign bus.out_imm      = out_imm_reg;
    assign bus.out_fmt      = out_fmt_reg;
    assign bus.out_rd       = out_rd_reg;
    assign bus.out_rf_we    = out_we_reg;
    assign bus.out_illegal  = out_ill_reg;

endmodule

// File: tb/tb_ysyx_22040088_idu_pipe.sv
// Directed bench for the decode stage: a table of single instructions plus
// hand-written sequences for stalls, backpressure, flush, x0, RV-E and reset.
module tb_ysyx_22040088_idu_pipe;

`ifdef YSYX_22040088_IDU_BYPASS_EN
    localparam int EXP_EXTRA = 0;
`else
    localparam int EXP_EXTRA = 1;
`endif

    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ysyx_22040088_idu_pipe_if #(.XLEN(64)) bus ();
    ysyx_22040088_idu_pipe_if #(.XLEN(64)) bus16 ();

    ysyx_22040088_idu_pipe #(.XLEN(64), .NREG(32)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    ysyx_22040088_idu_pipe #(.XLEN(64), .NREG(16)) u_dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        we;
        logic        ill;
        logic [63:0] rs1;
        logic [63:0] rs2;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic flush_cycle();
        bus.flush = 1'b1;
        cyc();
        bus.flush = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded, expected finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic fired;

        // x3=0x1234, x4=-16, x8=0x55 are preloaded below.
        vecs[0]  = '{32'hFFB00093, 64'hFFFF_FFFF_FFFF_FFFB, 3'd1, 1'b1, 1'b0, 64'd0, 64'd0};                    // addi x1,x0,-5
        vecs[1]  = '{32'h00418133, 64'd0, 3'd0, 1'b1, 1'b0, 64'h1234, 64'hFFFF_FFFF_FFFF_FFF0};                 // add x2,x3,x4
        vecs[2]  = '{32'hFE41AC23, 64'hFFFF_FFFF_FFFF_FFF8, 3'd2, 1'b0, 1'b0, 64'h1234, 64'hFFFF_FFFF_FFFF_FFF0}; // sw x4,-8(x3)
        vecs[3]  = '{32'hFE4188E3, 64'hFFFF_FFFF_FFFF_FFF0, 3'd3, 1'b0, 1'b0, 64'h1234, 64'hFFFF_FFFF_FFFF_FFF0}; // beq x3,x4,-16
        vecs[4]  = '{32'h800002B7, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b1, 1'b0, 64'd0, 64'd0};                    // lui x5,0x80000
        vecs[5]  = '{32'h001000EF, 64'h0000_0000_0000_0800, 3'd5, 1'b1, 1'b0, 64'd0, 64'd0};                    // jal x1,+2048
        vecs[6]  = '{32'hFFDFF06F, 64'hFFFF_FFFF_FFFF_FFFC, 3'd5, 1'b0, 1'b0, 64'd0, 64'd0};                    // jal x0,-4
        vecs[7]  = '{32'h12345317, 64'h0000_0000_1234_5000, 3'd4, 1'b1, 1'b0, 64'd0, 64'd0};                    // auipc x6 (fields hit x8/x3, unused)
        vecs[8]  = '{32'h0101A383, 64'h0000_0000_0000_0010, 3'd1, 1'b1, 1'b0, 64'h1234, 64'd0};                 // lw x7,16(x3)
        vecs[9]  = '{32'h0000007F, 64'd0, 3'd7, 1'b0, 1'b1, 64'd0, 64'd0};                                      // unknown opcode
        vecs[10] = '{32'h0041843B, 64'd0, 3'd0, 1'b1, 1'b0, 64'h1234, 64'hFFFF_FFFF_FFFF_FFF0};                 // addw x8,x3,x4
        vecs[11] = '{32'h00418033, 64'd0, 3'd0, 1'b0, 1'b0, 64'h1234, 64'hFFFF_FFFF_FFFF_FFF0};                 // add x0,x3,x4

        rst = 1'b0;
        bus.in_valid = 1'b0; bus.in_inst = 32'd0; bus.in_pc = 64'd0; bus.out_ready = 1'b1;
        bus.wb_valid = 1'b0; bus.wb_rd = 5'd0; bus.wb_data = 64'd0; bus.flush = 1'b0;
        bus16.in_valid = 1'b0; bus16.in_inst = 32'd0; bus16.in_pc = 64'd0; bus16.out_ready = 1'b1;
        bus16.wb_valid = 1'b0; bus16.wb_rd = 5'd0; bus16.wb_data = 64'd0; bus16.flush = 1'b0;
        cyc();
        cyc();

        // Reset state.
        chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset_out_imm", bus.out_imm, 64'd0);
        chk("reset_out_pc", bus.out_pc, 64'd0);
        chk("reset_out_rf_we", 64'(bus.out_rf_we), 64'd0);
        rst = 1'b1;
        #1;
        chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
        $display("reset released");

        // Preload source registers through the writeback port.
        bus.wb_valid = 1'b1;
        bus.wb_rd = 5'd3; bus.wb_data = 64'h1234;                cyc();
        bus.wb_rd = 5'd4; bus.wb_data = 64'hFFFF_FFFF_FFFF_FFF0; cyc();
        bus.wb_rd = 5'd8; bus.wb_data = 64'h55;                  cyc();
        bus.wb_valid = 1'b0;

        // Table: one instruction per entry, flushed afterwards to clear the scoreboard.
        for (int i = 0; i < NV; i++) begin
            bus.in_valid = 1'b1;
            bus.in_inst  = vecs[i].inst;
            bus.in_pc    = 64'h8000_0000 + 64'(i * 4);
            #1;
            chk("vec_in_ready", 64'(bus.in_ready), 64'd1);
            cyc();
            bus.in_valid = 1'b0;
            chk("vec_out_valid", 64'(bus.out_valid), 64'd1);
            chk("vec_pc", bus.out_pc, 64'h8000_0000 + 64'(i * 4));
            chk("vec_inst", 64'(bus.out_inst), 64'(vecs[i].inst));
            chk("vec_imm", bus.out_imm, vecs[i].imm);
            chk("vec_fmt", 64'(bus.out_fmt), 64'(vecs[i].fmt));
            chk("vec_rf_we", 64'(bus.out_rf_we), 64'(vecs[i].we));
            chk("vec_illegal", 64'(bus.out_illegal), 64'(vecs[i].ill));
            chk("vec_rs1", bus.out_rs1_data, vecs[i].rs1);
            chk("vec_rs2", bus.out_rs2_data, vecs[i].rs2);
            $display("vec %0d inst=%h imm=%h fmt=%0d we=%0d ill=%0d", i, vecs[i].inst,
                     bus.out_imm, bus.out_fmt, bus.out_rf_we, bus.out_illegal);
            flush_cycle();
        end

        // RAW stall: addi x1 then add x2,x1,x1 waits for writeback of x1=7.
        bus.in_valid = 1'b1; bus.in_inst = 32'hFFB00093; bus.in_pc = 64'h100;
        #1;
        chk("raw_addi_ready", 64'(bus.in_ready), 64'd1);
        cyc();
        bus.in_inst = 32'h00108133; bus.in_pc = 64'h104;
        chk("raw_addi_valid", 64'(bus.out_valid), 64'd1);
        chk("raw_addi_rd", 64'(bus.out_rd), 64'd1);
        #1;
        chk("raw_stall_ready", 64'(bus.in_ready), 64'd0);
        cyc();
        chk("raw_stall_ready2", 64'(bus.in_ready), 64'd0);
        chk("raw_drained_valid", 64'(bus.out_valid), 64'd0);
        bus.wb_valid = 1'b1; bus.wb_rd = 5'd1; bus.wb_data = 64'd7;
        n = 0;
        fired = 1'b0;
        for (int k = 0; k < 4 && !fired; k++) begin
            #1;
            if (bus.in_ready) fired = 1'b1;
            else n++;
            cyc();
            bus.wb_valid = 1'b0;
        end
        bus.in_valid = 1'b0;
        chk("raw_fired", 64'(fired), 64'd1);
        chk("raw_extra_cycles", 64'(n), 64'(EXP_EXTRA));
        chk("raw_add_rs1", bus.out_rs1_data, 64'd7);
        chk("raw_add_rs2", bus.out_rs2_data, 64'd7);
        chk("raw_add_pc", bus.out_pc, 64'h104);
        $display("raw sequence: add issued after %0d extra cycle(s)", n);
        flush_cycle();

        // Backpressure: entry held three cycles, next instruction waits, nothing lost.
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_inst = 32'h00100293; bus.in_pc = 64'h200; // addi x5,x0,1
        #1;
        chk("bp_first_ready", 64'(bus.in_ready), 64'd1);
        cyc();
        bus.in_inst = 32'h00200313; bus.in_pc = 64'h204;                     // addi x6,x0,2
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_hold_valid", 64'(bus.out_valid), 64'd1);
            chk("bp_hold_imm", bus.out_imm, 64'd1);
            chk("bp_hold_rd", 64'(bus.out_rd), 64'd5);
            chk("bp_hold_ready", 64'(bus.in_ready), 64'd0);
            cyc();
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 64'(bus.in_ready), 64'd1);
        cyc();
        bus.in_valid = 1'b0;
        chk("bp_second_valid", 64'(bus.out_valid), 64'd1);
        chk("bp_second_imm", bus.out_imm, 64'd2);
        chk("bp_second_rd", 64'(bus.out_rd), 64'd6);
        cyc();
        chk("bp_drain_valid", 64'(bus.out_valid), 64'd0);
        $display("backpressure sequence done");
        flush_cycle();

        // Flush with a held entry and x5 busy; a fresh write to x5 is accepted right after.
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_inst = 32'h00100293; bus.in_pc = 64'h300;
        cyc();
        bus.in_valid = 1'b0;
        chk("flush_pre_valid", 64'(bus.out_valid), 64'd1);
        bus.flush = 1'b1;
        #1;
        chk("flush_in_ready", 64'(bus.in_ready), 64'd0);
        cyc();
        bus.flush = 1'b0;
        chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
        bus.in_valid = 1'b1; bus.in_inst = 32'h00300293; bus.in_pc = 64'h304;
        #1;
        chk("flush_busy_cleared", 64'(bus.in_ready), 64'd1);
        cyc();
        bus.in_valid = 1'b0;
        chk("flush_next_valid", 64'(bus.out_valid), 64'd1);
        chk("flush_next_imm", bus.out_imm, 64'd3);
        $display("flush sequence done");
        bus.out_ready = 1'b1;
        flush_cycle();

        // Writes to x0 are dropped.
        bus.wb_valid = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 64'hDEAD;
        cyc();
        bus.wb_valid = 1'b0;
        bus.in_valid = 1'b1; bus.in_inst = 32'h003004B3; bus.in_pc = 64'h400; // add x9,x0,x3
        cyc();
        bus.in_valid = 1'b0;
        chk("x0_rs1", bus.out_rs1_data, 64'd0);
        chk("x0_rs2", bus.out_rs2_data, 64'h1234);
        $display("x0 sequence done");
        flush_cycle();

        // RV-E instance: register index 16 and above is illegal.
        bus16.in_valid = 1'b1; bus16.in_inst = 32'h002088B3;                 // add x17,x1,x2
        cyc();
        chk("rve_rd17_illegal", 64'(bus16.out_illegal), 64'd1);
        chk("rve_rd17_we", 64'(bus16.out_rf_we), 64'd0);
        bus16.in_inst = 32'h002880B3;                                        // add x1,x17,x2
        cyc();
        chk("rve_rs17_illegal", 64'(bus16.out_illegal), 64'd1);
        bus16.in_inst = 32'h00418133;                                        // add x2,x3,x4
        cyc();
        bus16.in_valid = 1'b0;
        chk("rve_legal_illegal", 64'(bus16.out_illegal), 64'd0);
        chk("rve_legal_we", 64'(bus16.out_rf_we), 64'd1);
        chk("rve_legal_fmt", 64'(bus16.out_fmt), 64'd0);
        $display("rv-e sequence done");

        // Reset in the middle of a RAW stall.
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_inst = 32'hFFB00093; bus.in_pc = 64'h500;
        cyc();
        bus.in_inst = 32'h00108133; bus.in_pc = 64'h504;
        #1;
        chk("rst_pre_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_pre_valid", 64'(bus.out_valid), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_async_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_async_imm", bus.out_imm, 64'd0);
        chk("rst_async_pc", bus.out_pc, 64'd0);
        cyc();
        rst = 1'b1;
        #1;
        chk("rst_busy_cleared", 64'(bus.in_ready), 64'd1);
        cyc();
        bus.in_valid = 1'b0;
        chk("rst_after_valid", 64'(bus.out_valid), 64'd1);
        chk("rst_regfile_x1", bus.out_rs1_data, 64'd0);
        $display("reset sequence done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
